// File: rtl/data_bus_responder.sv
// Data-side bus responder: word-addressed scratch RAM plus an MMIO window with TX FIFO, STATUS and CYCLES.
// Define DATA_BUS_RESPONDER_CYCLES_EN to build the free-running CYCLES counter at MMIO_BASE+8.
module data_bus_responder #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           RAM_WORDS  = 256,
  parameter int unsigned           FIFO_DEPTH = 8,
  parameter logic [DATA_WIDTH-1:0] MMIO_BASE  = DATA_WIDTH'(32'h0000_1000)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  err_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  irq_o
);

  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam int unsigned FIFO_AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W     = FIFO_AW + 1;
  localparam int unsigned RAM_BYTES = RAM_WORDS * 4;

  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
  logic [7:0]            fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count;
  logic                  ovf, irq_en, ovf_n, irq_en_n;
  logic [DATA_WIDTH-1:0] q_n, status, cyc_val;
  logic [7:0]            tx_data_n;
  logic                  tx_valid_n, err_n;
  logic                  aligned, hit_ram, hit_tx, hit_st, hit_cyc, access;
  logic                  empty, full, pop, push_req, push;
  logic [RAM_AW-1:0]     ram_idx;

`ifdef DATA_BUS_RESPONDER_CYCLES_EN
  logic [31:0] cycles;
  assign cyc_val = DATA_WIDTH'(cycles);
  assign hit_cyc = aligned && (addr_i == MMIO_BASE + DATA_WIDTH'(8));

  // Write clears; otherwise free-running with natural wrap.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                  cycles <= '0;
    else if (wr_en_i && hit_cyc)   cycles <= '0;
    else                           cycles <= cycles + 32'd1;
  end
`else
  assign cyc_val = '0;
  assign hit_cyc = 1'b0;
`endif

  // Address decode and FIFO occupancy
  always_comb begin
    access   = rd_en_i | wr_en_i;
    aligned  = (addr_i[1:0] == 2'b00);
    hit_ram  = aligned && (addr_i < DATA_WIDTH'(RAM_BYTES));
    hit_tx   = aligned && (addr_i == MMIO_BASE);
    hit_st   = aligned && (addr_i == MMIO_BASE + DATA_WIDTH'(4));
    ram_idx  = addr_i[RAM_AW+1:2];
    count    = wr_ptr - rd_ptr;
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
               (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
    pop      = tx_valid_o && tx_ready_i;
    push_req = wr_en_i && hit_tx;
    push     = push_req && (!full || pop);
  end

  // Next-state and next-output computation
  always_comb begin
    status      = '0;
    status[16]  = irq_en;
    status[15]  = ovf;
    status[14:8] = 7'(count);
    status[1]   = full;
    status[0]   = empty;

    q_n      = q_o;
    err_n    = access && !(hit_ram || hit_tx || hit_st || hit_cyc);
    ovf_n    = ovf;
    irq_en_n = irq_en;

    if (rd_en_i) begin
      if (hit_ram)      q_n = ram[ram_idx];
      else if (hit_st)  q_n = status;
      else if (hit_cyc) q_n = cyc_val;
      else              q_n = '0;
    end

    if (push_req && !push) ovf_n = 1'b1;
    if (wr_en_i && hit_st) begin
      irq_en_n = data_i[16];
      if (data_i[15]) ovf_n = 1'b0;
    end

    wr_ptr_n   = wr_ptr + PTR_W'(push);
    rd_ptr_n   = rd_ptr + PTR_W'(pop);
    tx_valid_n = (wr_ptr_n != rd_ptr_n);

    // Head byte may be the one being pushed this edge (bypass the array write).
    if (!tx_valid_n)
      tx_data_n = 8'h00;
    else if (push && (wr_ptr[FIFO_AW-1:0] == rd_ptr_n[FIFO_AW-1:0]))
      tx_data_n = data_i[7:0];
    else
      tx_data_n = fifo_mem[rd_ptr_n[FIFO_AW-1:0]];
  end

  // Control and output registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      q_o        <= '0;
      err_o      <= 1'b0;
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
      irq_o      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf        <= 1'b0;
      irq_en     <= 1'b0;
    end else begin
      q_o        <= q_n;
      err_o      <= err_n;
      tx_data_o  <= tx_data_n;
      tx_valid_o <= tx_valid_n;
      irq_o      <= ovf & irq_en;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      ovf        <= ovf_n;
      irq_en     <= irq_en_n;
    end
  end

  // Storage arrays are not reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i && hit_ram) ram[ram_idx] <= data_i;
    if (push)               fifo_mem[wr_ptr[FIFO_AW-1:0]] <= data_i[7:0];
  end

endmodule
